// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory bus bundle for mem_port_arbiter
//
// Signals:
//   d_req/d_rw/d_addr/d_wdata/d_size  data-port request, held stable until d_gnt
//   d_gnt/d_stall/d_rvalid/d_rdata    data-port grant, stall and read response
//   i_req/i_addr                      fetch request (always a word read)
//   i_gnt/i_stall/i_rvalid/i_rdata    fetch grant, stall and read response
//   mem_en/mem_rw/mem_addr/mem_wdata/mem_size  single-ported memory command
//   mem_rdata                         memory read data, MEM_LATENCY cycles after mem_en
// Modports: slave = arbiter side, master = requesters plus memory model side.
interface mem_port_arbiter_if;
    logic        d_req;
    logic        d_rw;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_size;
    logic        d_gnt;
    logic        d_stall;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_stall;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        mem_en;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic [31:0] mem_rdata;

    modport slave (
        input  d_req, d_rw, d_addr, d_wdata, d_size, i_req, i_addr, mem_rdata,
        output d_gnt, d_stall, d_rvalid, d_rdata,
        output i_gnt, i_stall, i_rvalid, i_rdata,
        output mem_en, mem_rw, mem_addr, mem_wdata, mem_size
    );

    modport master (
        output d_req, d_rw, d_addr, d_wdata, d_size, i_req, i_addr, mem_rdata,
        input  d_gnt, d_stall, d_rvalid, d_rdata,
        input  i_gnt, i_stall, i_rvalid, i_rdata,
        input  mem_en, mem_rw, mem_addr, mem_wdata, mem_size
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shared memory arbiter between fetch and data ports
//
// Grants one memory access per cycle to the data or fetch requester, tags every
// read in flight and steers mem_rdata back to the owner after MEM_LATENCY cycles.
// Data wins conflicts unless the fetch port has lost STARVE_LIMIT in a row.
//
// Parameters: MEM_LATENCY (1..4), STARVE_LIMIT (1..15)
// Ports:
//   clock, reset  clock and synchronous active-high reset
//   bus           mem_port_arbiter_if.slave (requests, grants, stalls, responses, memory bus)
//   perf_d_grants, perf_i_grants, perf_i_stall  event counters, only with ARB_PERF_CNT_EN
// Optional macro: ARB_PERF_CNT_EN adds the three performance counters.
module mem_port_arbiter #(
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clock,
    input  logic              reset,
`ifdef ARB_PERF_CNT_EN
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_i_grants,
    output logic [31:0]       perf_i_stall,
`endif
    mem_port_arbiter_if.slave bus
);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic                   conflict;
    logic                   fetch_wins;
    logic                   d_grant;
    logic                   i_grant;
    logic [3:0]             starve_q, starve_d;
    // One slot per latency cycle: vld marks a read in flight, tag 1 = fetch owner.
    logic [MEM_LATENCY-1:0] vld_q, vld_d;
    logic [MEM_LATENCY-1:0] tag_q, tag_d;
    logic                   resp_v;
    logic                   resp_t;

    // Grants are suppressed during reset so nothing enters the response pipe.
    assign conflict   = bus.d_req & bus.i_req;
    assign fetch_wins = conflict & (starve_q == STARVE_MAX);
    assign d_grant    = ~reset & bus.d_req & ~fetch_wins;
    assign i_grant    = ~reset & bus.i_req & ~d_grant;

    assign bus.d_gnt   = d_grant;
    assign bus.i_gnt   = i_grant;
    assign bus.d_stall = ~reset & bus.d_req & ~d_grant;
    assign bus.i_stall = ~reset & bus.i_req & ~i_grant;

    always_comb begin
        bus.mem_en    = d_grant | i_grant;
        bus.mem_rw    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_size  = '0;
        if (d_grant) begin
            bus.mem_rw    = bus.d_rw;
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
            bus.mem_size  = bus.d_size;
        end else if (i_grant) begin
            bus.mem_addr  = bus.i_addr;
            bus.mem_size  = 2'd2;
        end
    end

    // The tail slot is masked during reset so a response due that cycle is dropped.
    assign resp_v       = ~reset & vld_q[MEM_LATENCY-1];
    assign resp_t       = tag_q[MEM_LATENCY-1];
    assign bus.d_rvalid = resp_v & ~resp_t;
    assign bus.i_rvalid = resp_v & resp_t;
    assign bus.d_rdata  = (resp_v & ~resp_t) ? bus.mem_rdata : '0;
    assign bus.i_rdata  = (resp_v & resp_t) ? bus.mem_rdata : '0;

    always_comb begin
        starve_d = starve_q;
        if (i_grant) begin
            starve_d = '0;
        end else if (conflict && d_grant) begin
            starve_d = starve_q + 4'd1;
        end

        vld_d    = '0;
        tag_d    = '0;
        vld_d[0] = (d_grant & ~bus.d_rw) | i_grant;
        tag_d[0] = i_grant;
        for (int k = 1; k < MEM_LATENCY; k++) begin
            vld_d[k] = vld_q[k-1];
            tag_d[k] = tag_q[k-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_q <= '0;
            vld_q    <= '0;
            tag_q    <= '0;
        end else begin
            starve_q <= starve_d;
            vld_q    <= vld_d;
            tag_q    <= tag_d;
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_d_q, perf_d_d;
    logic [31:0] perf_i_q, perf_i_d;
    logic [31:0] perf_s_q, perf_s_d;

    always_comb begin
        perf_d_d = perf_d_q + {31'b0, d_grant};
        perf_i_d = perf_i_q + {31'b0, i_grant};
        perf_s_d = perf_s_q + {31'b0, bus.i_stall};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_d_q <= '0;
            perf_i_q <= '0;
            perf_s_q <= '0;
        end else begin
            perf_d_q <= perf_d_d;
            perf_i_q <= perf_i_d;
            perf_s_q <= perf_s_d;
        end
    end

    assign perf_d_grants = reset ? '0 : perf_d_q;
    assign perf_i_grants = reset ? '0 : perf_i_q;
    assign perf_i_stall  = reset ? '0 : perf_s_q;
`endif
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates one shared single-ported memory between the fetch requester (instruction port) and the memory-stage requester (data port) of the 5-stage pipeline. Grants at most one access per cycle and tags each read in flight. Returns read data to the correct requester after the fixed memory latency. Raises a per-port stall so the pipeline control freezes the losing stage.

Parameters:
MEM_LATENCY, 1, cycles from grant to mem_rdata valid; legal range 1..4.
STARVE_LIMIT, 3, consecutive lost conflicts after which the fetch port wins the next conflict; legal range 1..15.

Ports:
clock  input  1  clock
reset  input  1  reset, synchronous, active-high
d_req  input  1  data-port request; held with stable fields until d_gnt
d_rw  input  1  1 = write, 0 = read
d_addr  input  32  data address
d_wdata  input  32  write data
d_size  input  2  access size; 0 = byte, 1 = half, 2 = word
d_gnt  output  1  data request accepted this cycle
d_stall  output  1  d_req & ~d_gnt
d_rvalid  output  1  data read response valid
d_rdata  output  32  data read response
i_req  input  1  fetch request; always a word read
i_addr  input  32  fetch address
i_gnt  output  1  fetch request accepted this cycle
i_stall  output  1  i_req & ~i_gnt
i_rvalid  output  1  fetch response valid
i_rdata  output  32  fetch response
mem_en  output  1  memory access this cycle
mem_rw  output  1  1 = write
mem_addr  output  32  memory address
mem_wdata  output  32  memory write data
mem_size  output  2  memory access size
mem_rdata  input  32  memory read data, valid MEM_LATENCY cycles after mem_en

Behaviour:
- Grant is combinational from the current req inputs and the registered arbitration state. d_gnt and i_gnt are never both 1.
- Priority:
  - Only one port requesting: that port is granted.
  - Both requesting: the data port wins, unless starve_cnt == STARVE_LIMIT, in which case the fetch port wins.
- starve_cnt is a 4-bit register:
  - +1 on each cycle where both ports request and the data port is granted.
  - Cleared on any i_gnt.
  - Holds otherwise.
- Memory bus: mem_en = d_gnt | i_gnt. mem_addr, mem_rw, mem_wdata and mem_size are muxed from the granted port.
  - Fetch grant drives mem_rw = 0 and mem_size = 2.
  - When idle, all mem_* outputs are 0.
- Response tracking:
  - A MEM_LATENCY-deep shift register carries {valid, tag} per grant, with tag 0 = data and tag 1 = fetch.
  - A valid bit is set only for reads; writes produce no response.
  - At the tail of the shift register: d_rvalid = valid & ~tag, and i_rvalid = valid & tag.
  - d_rdata and i_rdata both equal mem_rdata when their rvalid is 1, and 0 otherwise.
- Latency: a read granted in cycle N has its rvalid high in cycle N + MEM_LATENCY, for exactly one cycle.
- Throughput: one grant per cycle back-to-back. Responses return in grant order.
- Reset:
  - All outputs read 0 while reset is sampled high.
  - starve_cnt and the shift register are cleared.
  - In-flight reads at reset are dropped; no rvalid follows.
  - Grants are suppressed while reset is high.
- A requester that deasserts req before its grant is a protocol violation; the result is undefined.

Optional Feature:
ARB_PERF_CNT_EN:
- When defined, adds three 32-bit outputs, each cleared on reset and wrapping modulo 2^32:
  - perf_d_grants: count of d_gnt cycles.
  - perf_i_grants: count of i_gnt cycles.
  - perf_i_stall: count of i_stall cycles.
- When undefined, these ports and their registers do not exist; behaviour is otherwise identical.

Test Plan:
- Fetch only, i_addr = 0x01000000, MEM_LATENCY = 1, mem_rdata = 0x00000013 -> i_gnt same cycle; i_rvalid = 1 with i_rdata = 0x00000013 next cycle; d_rvalid stays 0.
- Both requesting continuously, STARVE_LIMIT = 3 -> grant sequence d,d,d,i,d,d,d,i; i_stall high on the d cycles; starve_cnt returns to 0 after each i grant.
- Data write d_addr = 0x01000100, d_wdata = 0xDEADBEEF, d_size = 2 -> mem_en = 1, mem_rw = 1, mem_wdata = 0xDEADBEEF; no d_rvalid ever.
- MEM_LATENCY = 3, alternating d-read and i-read grants in cycles 10..13 -> rvalid pulses in cycles 13..16 with matching tags, each carrying the mem_rdata present that cycle.
- Reads granted in cycles 5 and 6 with MEM_LATENCY = 2, reset high in cycle 7 -> no rvalid in cycles 7 or 8; all outputs 0 during reset; normal grant in the first cycle after reset deasserts.
- With ARB_PERF_CNT_EN, 4 d grants and 2 i grants with 3 i_stall cycles -> perf counters read 4, 2 and 3; all cleared by reset.
